// File: rtl/vx_perf_memsys_reader_if.sv
// ----------------------------------------------------------------------------
// VX_perf_memsys_if
//   Bundle of the 15 live memory-system performance counters, each
//   PERF_CTR_BITS wide. The counter source drives the bundle through the
//   master modport. The vx_perf_memsys_reader samples it through the slave
//   modport.
// ----------------------------------------------------------------------------
interface VX_perf_memsys_if #(
  parameter int unsigned PERF_CTR_BITS = 44
) ();
  logic [PERF_CTR_BITS-1:0] icache_reads;
  logic [PERF_CTR_BITS-1:0] icache_read_misses;
  logic [PERF_CTR_BITS-1:0] dcache_reads;
  logic [PERF_CTR_BITS-1:0] dcache_writes;
  logic [PERF_CTR_BITS-1:0] dcache_read_misses;
  logic [PERF_CTR_BITS-1:0] dcache_write_misses;
  logic [PERF_CTR_BITS-1:0] dcache_bank_stalls;
  logic [PERF_CTR_BITS-1:0] dcache_mshr_stalls;
  logic [PERF_CTR_BITS-1:0] smem_reads;
  logic [PERF_CTR_BITS-1:0] smem_writes;
  logic [PERF_CTR_BITS-1:0] smem_bank_stalls;
  logic [PERF_CTR_BITS-1:0] mem_reads;
  logic [PERF_CTR_BITS-1:0] mem_writes;
  logic [PERF_CTR_BITS-1:0] mem_latency;
  logic [PERF_CTR_BITS-1:0] dup_accesses;

  modport master (
    output icache_reads, icache_read_misses, dcache_reads, dcache_writes,
           dcache_read_misses, dcache_write_misses, dcache_bank_stalls,
           dcache_mshr_stalls, smem_reads, smem_writes, smem_bank_stalls,
           mem_reads, mem_writes, mem_latency, dup_accesses
  );

  modport slave (
    input  icache_reads, icache_read_misses, dcache_reads, dcache_writes,
           dcache_read_misses, dcache_write_misses, dcache_bank_stalls,
           dcache_mshr_stalls, smem_reads, smem_writes, smem_bank_stalls,
           mem_reads, mem_writes, mem_latency, dup_accesses
  );
endinterface

// File: rtl/vx_perf_memsys_reader.sv
// ----------------------------------------------------------------------------
// vx_perf_memsys_reader
//   Reads the 15 memory-system performance counters (PERF_CTR_BITS wide) back
//   as 32-bit words over a valid/ready request/response handshake.
//   - A lo read (req_hi=0) returns bits [31:0]. It also latches the full
//     counter into a hold register.
//   - A hi read (req_hi=1) of the held index returns the upper bits of that
//     held copy. This keeps a lo/hi pair coherent even if the counter carries
//     between the two reads.
//   - An index of 15 or more returns data 0 with rsp_err=1.
//   Optional feature, enabled with macro PERF_SNAPSHOT_EN:
//   - snap_req copies all counters into a snapshot bank.
//   - All reads are then served from that bank.
//
// Ports
//   clk            : single clock
//   reset_n        : asynchronous active-low reset
//   perf_memsys_if : slave modport, live counters
//   snap_req       : snapshot strobe (ignored without PERF_SNAPSHOT_EN)
//   req_valid/req_ready, req_idx[4:0], req_hi : read request
//   rsp_valid/rsp_ready, rsp_data[31:0], rsp_err : read response
// ----------------------------------------------------------------------------
module vx_perf_memsys_reader #(
  parameter int unsigned PERF_CTR_BITS = 44
) (
  input  logic                   clk,
  input  logic                   reset_n,
  VX_perf_memsys_if.slave        perf_memsys_if,
  input  logic                   snap_req,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [4:0]             req_idx,
  input  logic                   req_hi,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err
);

  localparam int unsigned NUM_CTRS = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [31:0]              rsp_data_q, rsp_data_d;
  logic                     rsp_err_q, rsp_err_d;
  logic [PERF_CTR_BITS-1:0] hold_q, hold_d;
  logic [4:0]               hold_idx_q, hold_idx_d;
  logic                     hold_vld_q, hold_vld_d;

  logic [PERF_CTR_BITS-1:0] live [NUM_CTRS];
  logic [PERF_CTR_BITS-1:0] src  [NUM_CTRS];
  logic [PERF_CTR_BITS-1:0] sel_val;
  logic [PERF_CTR_BITS-1:0] hi_src;
  logic                     idx_ok;
  logic                     use_hold;

  assign live[0]  = perf_memsys_if.icache_reads;
  assign live[1]  = perf_memsys_if.icache_read_misses;
  assign live[2]  = perf_memsys_if.dcache_reads;
  assign live[3]  = perf_memsys_if.dcache_writes;
  assign live[4]  = perf_memsys_if.dcache_read_misses;
  assign live[5]  = perf_memsys_if.dcache_write_misses;
  assign live[6]  = perf_memsys_if.dcache_bank_stalls;
  assign live[7]  = perf_memsys_if.dcache_mshr_stalls;
  assign live[8]  = perf_memsys_if.smem_reads;
  assign live[9]  = perf_memsys_if.smem_writes;
  assign live[10] = perf_memsys_if.smem_bank_stalls;
  assign live[11] = perf_memsys_if.mem_reads;
  assign live[12] = perf_memsys_if.mem_writes;
  assign live[13] = perf_memsys_if.mem_latency;
  assign live[14] = perf_memsys_if.dup_accesses;

`ifdef PERF_SNAPSHOT_EN
  logic [PERF_CTR_BITS-1:0] bank_q [NUM_CTRS];
  logic [PERF_CTR_BITS-1:0] bank_d [NUM_CTRS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      bank_d[i] = snap_req ? live[i] : bank_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  // Reads use bank_q, so a read accepted in the same cycle as a capture
  // sees the contents from before that capture.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      src[i] = bank_q[i];
    end
  end
`else
  logic unused_snap_req;
  assign unused_snap_req = snap_req;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      src[i] = live[i];
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    hold_d     = hold_q;
    hold_idx_d = hold_idx_q;
    hold_vld_d = hold_vld_q;

    sel_val = '0;
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      if (req_idx == 5'(i)) begin
        sel_val = src[i];
      end
    end
    idx_ok   = (req_idx < 5'(NUM_CTRS));
    use_hold = hold_vld_q && (hold_idx_q == req_idx);
    hi_src   = use_hold ? hold_q : sel_val;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_RESP;
          if (!idx_ok) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end else if (!req_hi) begin
            rsp_data_d = sel_val[31:0];
            rsp_err_d  = 1'b0;
            hold_d     = sel_val;
            hold_idx_d = req_idx;
            hold_vld_d = 1'b1;
          end else begin
            rsp_data_d = 32'(hi_src >> 32);
            rsp_err_d  = 1'b0;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      hold_q     <= '0;
      hold_idx_q <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_vx_perf_memsys_reader.sv
module tb_vx_perf_memsys_reader;

  localparam int unsigned W = 44;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        snap_req;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_idx;
  logic        req_hi;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

`ifdef PERF_SNAPSHOT_EN
  localparam logic [31:0] EXP_SNAP_MEMRD = 32'd100;
  localparam logic [31:0] EXP_SAME_CYC   = 32'h0000_0007;
`else
  localparam logic [31:0] EXP_SNAP_MEMRD = 32'd150;
  localparam logic [31:0] EXP_SAME_CYC   = 32'h0000_0009;
`endif

  always #5 clk = ~clk;

  VX_perf_memsys_if #(.PERF_CTR_BITS(W)) pm_if ();

  vx_perf_memsys_reader #(.PERF_CTR_BITS(W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .perf_memsys_if (pm_if),
    .snap_req       (snap_req),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_idx        (req_idx),
    .req_hi         (req_hi),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err)
  );

  // Monitor: every delivered response is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp: got data=%08h err=%0d, no response expected",
                 rsp_data, rsp_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({rsp_err, rsp_data} !== {e.err, e.data}) begin
          bad++;
          $display("FAIL %s: got data=%08h err=%0d, want data=%08h err=%0d",
                   e.name, rsp_data, rsp_err, e.data, e.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic set_ctr(input int unsigned idx, input logic [W-1:0] v);
    case (idx)
      0:  pm_if.icache_reads        = v;
      1:  pm_if.icache_read_misses  = v;
      2:  pm_if.dcache_reads        = v;
      3:  pm_if.dcache_writes       = v;
      4:  pm_if.dcache_read_misses  = v;
      5:  pm_if.dcache_write_misses = v;
      6:  pm_if.dcache_bank_stalls  = v;
      7:  pm_if.dcache_mshr_stalls  = v;
      8:  pm_if.smem_reads          = v;
      9:  pm_if.smem_writes         = v;
      10: pm_if.smem_bank_stalls    = v;
      11: pm_if.mem_reads           = v;
      12: pm_if.mem_writes          = v;
      13: pm_if.mem_latency         = v;
      default: pm_if.dup_accesses   = v;
    endcase
  endtask

  task automatic pulse_snap();
    snap_req = 1'b1;
    @(posedge clk); #1;
    snap_req = 1'b0;
  endtask

  // Issues one request; returns #1 after the accepting edge.
  task automatic do_read(input string name, input logic [4:0] idx, input logic hi,
                         input logic [31:0] exp_d, input logic exp_e,
                         input bit push, input bit with_snap);
    int unsigned n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL %s_req_timeout: got req_ready=%0d want 1", name, req_ready);
    end else begin
      if (push) begin
        e.name = name;
        e.data = exp_d;
        e.err  = exp_e;
        exp_q.push_back(e);
      end
      req_valid = 1'b1;
      req_idx   = idx;
      req_hi    = hi;
      if (with_snap) snap_req = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      snap_req  = 1'b0;
    end
  endtask

  initial begin
    reset_n   = 1'b1;
    snap_req  = 1'b0;
    req_valid = 1'b0;
    req_idx   = '0;
    req_hi    = 1'b0;
    rsp_ready = 1'b1;
    for (int unsigned i = 0; i < 15; i++) set_ctr(i, '0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_data",  64'(rsp_data),  64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    #20 reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic lo/hi reads, hi read of a non-held index comes from the source.
    set_ctr(2,  44'h0AB_1234_5678);
    set_ctr(0,  44'h155_0000_0042);
    set_ctr(14, 44'hFFF_FFFF_FFFF);
    pulse_snap();
    do_read("lo2",  5'd2,  1'b0, 32'h1234_5678, 1'b0, 1, 0);
    do_read("hi2",  5'd2,  1'b1, 32'h0000_00AB, 1'b0, 1, 0);
    do_read("hi0",  5'd0,  1'b1, 32'h0000_0155, 1'b0, 1, 0);
    do_read("lo14", 5'd14, 1'b0, 32'hFFFF_FFFF, 1'b0, 1, 0);
    do_read("hi14", 5'd14, 1'b1, 32'h0000_0FFF, 1'b0, 1, 0);

    // Carry between lo and hi reads: hold register keeps the pair coherent.
    set_ctr(13, 44'h001_FFFF_FFFF);
    pulse_snap();
    do_read("lo13", 5'd13, 1'b0, 32'hFFFF_FFFF, 1'b0, 1, 0);
    set_ctr(13, 44'h002_0000_0000);
    pulse_snap();
    do_read("hi13",       5'd13, 1'b1, 32'h0000_0001, 1'b0, 1, 0);
    do_read("hi13_again", 5'd13, 1'b1, 32'h0000_0001, 1'b0, 1, 0);

    // Out-of-range indices report an error and leave the hold register alone.
    do_read("lo2_b", 5'd2, 1'b0, 32'h1234_5678, 1'b0, 1, 0);
    set_ctr(2, 44'h0CD_1234_5678);
    pulse_snap();
    do_read("err20",      5'd20, 1'b0, 32'h0, 1'b1, 1, 0);
    do_read("err15",      5'd15, 1'b1, 32'h0, 1'b1, 1, 0);
    do_read("hi2_held",   5'd2,  1'b1, 32'h0000_00AB, 1'b0, 1, 0);

    // Snapshot isolation from later counter changes.
    set_ctr(11, 44'd100);
    pulse_snap();
    set_ctr(11, 44'd150);
    do_read("snap_lo11", 5'd11, 1'b0, EXP_SNAP_MEMRD, 1'b0, 1, 0);

    // A snapshot and a read accepted together: the read sees the old bank.
    set_ctr(12, 44'h011_0000_0007);
    pulse_snap();
    set_ctr(12, 44'h022_0000_0009);
    do_read("samecyc_lo12", 5'd12, 1'b0, EXP_SAME_CYC,  1'b0, 1, 1);
    do_read("after_lo12",   5'd12, 1'b0, 32'h0000_0009, 1'b0, 1, 0);
    do_read("after_hi12",   5'd12, 1'b1, 32'h0000_0022, 1'b0, 1, 0);

    // Backpressure: response held stable, counters/snap/requests ignored.
    set_ctr(8, 44'h005_DEAD_BEEF);
    pulse_snap();
    rsp_ready = 1'b0;
    do_read("stall_lo8", 5'd8, 1'b0, 32'hDEAD_BEEF, 1'b0, 1, 0);
    for (int c = 0; c < 5; c++) begin
      check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      check("stall_rsp_data",  64'(rsp_data),  64'hDEAD_BEEF);
      check("stall_rsp_err",   64'(rsp_err),   64'd0);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      if (c == 1) begin
        set_ctr(8, '0);
        snap_req  = 1'b1;
        req_valid = 1'b1;
        req_idx   = 5'd20;
      end
      if (c == 3) begin
        snap_req  = 1'b0;
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("release_req_ready", 64'(req_ready), 64'd1);
    check("release_rsp_valid", 64'(rsp_valid), 64'd0);
    do_read("hold_hi8", 5'd8, 1'b1, 32'h0000_0005, 1'b0, 1, 0);

    // Reset in the middle of a pending response drops it and clears the hold.
    set_ctr(3, 44'h0F0_AAAA_5555);
    pulse_snap();
    rsp_ready = 1'b0;
    do_read("drop_lo3", 5'd3, 1'b0, 32'h0, 1'b0, 0, 0);
    check("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_rsp_data",  64'(rsp_data),  64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req_ready", 64'(req_ready), 64'd1);
    check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    set_ctr(3, 44'h3C3_0000_0001);
    pulse_snap();
    do_read("post_rst_hi3", 5'd3, 1'b1, 32'h0000_03C3, 1'b0, 1, 0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
